universal_seq_gen: RTL

Serial pattern transmitter, the transmit end of the universal 3-bit sequence detector link. On a start request it latches a 3-bit pattern and shifts it MSB-first onto a one-bit serial line, repeating it a programmed number of times with a programmable idle gap between repetitions. Its `xout` drives the detector's serial input `xin`, which gives benches and on-chip self-test a known stimulus source. Alignment strobes mark each pattern bit and the final bit of each repetition.

---
 rtl/universal_seq_gen_if.sv | 43 ++++
 rtl/universal_seq_gen.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/universal_seq_gen_if.sv
// rtl/universal_seq_gen_if.sv - request/serial-line bundle for universal_seq_gen
//
// Request side (driven by the requester, read by the generator):
//   start     transmit request, honoured only when the generator is idle
//   inp_seq   3-bit pattern, bit 2 goes out first
//   rep_cnt   number of repetitions (0 = send nothing)
//   gap       idle cycles between consecutive repetitions
//   idle_lvl  line level outside pattern bits
// Line side (driven by the generator):
//   xout      serial data line
//   bit_valid xout carries a pattern bit
//   last      bit 0 of a repetition is on the line
//   busy      transmission in progress
//   done      one-cycle pulse after the final bit of the final repetition

interface universal_seq_gen_if #(
  parameter int CNT_W = 4,
  parameter int GAP_W = 4
);

  logic             start;
  logic [2:0]       inp_seq;
  logic [CNT_W-1:0] rep_cnt;
  logic [GAP_W-1:0] gap;
  logic             idle_lvl;

  logic             xout;
  logic             bit_valid;
  logic             last;
  logic             busy;
  logic             done;

  modport master (
    output start, inp_seq, rep_cnt, gap, idle_lvl,
    input  xout, bit_valid, last, busy, done
  );

  modport slave (
    input  start, inp_seq, rep_cnt, gap, idle_lvl,
    output xout, bit_valid, last, busy, done
  );

endinterface

// File: rtl/universal_seq_gen.sv
// rtl/universal_seq_gen.sv - repeating 3-bit serial pattern transmitter
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset; abandons any transmission
//   bus    universal_seq_gen_if.slave: request inputs and registered line outputs
//
// A start accepted in IDLE latches the pattern, repetition count, gap and idle
// level; the pattern then goes out MSB-first, each repetition separated by
// gap idle cycles, followed by a single DONE cycle.

module universal_seq_gen #(
  parameter int CNT_W = 4,
  parameter int GAP_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  universal_seq_gen_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] REP_ONE = CNT_W'(1);
  localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

  state_t           state_q, state_d;
  logic [2:0]       seq_q, seq_d;
  logic             lvl_q, lvl_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0] reps_left_q, reps_left_d;
  logic [1:0]       idx_q, idx_d;

  logic xout_q, xout_d;
  logic bit_valid_q, bit_valid_d;
  logic last_q, last_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      seq_q       <= '0;
      lvl_q       <= 1'b0;
      gap_q       <= '0;
      gap_cnt_q   <= '0;
      reps_left_q <= '0;
      idx_q       <= '0;
      xout_q      <= 1'b0;
      bit_valid_q <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      seq_q       <= seq_d;
      lvl_q       <= lvl_d;
      gap_q       <= gap_d;
      gap_cnt_q   <= gap_cnt_d;
      reps_left_q <= reps_left_d;
      idx_q       <= idx_d;
      xout_q      <= xout_d;
      bit_valid_q <= bit_valid_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    seq_d       = seq_q;
    lvl_d       = lvl_q;
    gap_d       = gap_q;
    gap_cnt_d   = gap_cnt_q;
    reps_left_d = reps_left_q;
    idx_d       = idx_q;

    case (state_q)
      IDLE: begin
        if (bus.start && (bus.rep_cnt != '0)) begin
          seq_d       = bus.inp_seq;
          reps_left_d = bus.rep_cnt;
          gap_d       = bus.gap;
          lvl_d       = bus.idle_lvl;
          idx_d       = 2'd2;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (idx_q != 2'd0) begin
          idx_d = idx_q - 2'd1;
        end else if (reps_left_q == REP_ONE) begin
          // Final repetition: counter is left at 1 rather than wrapping to 0.
          state_d = DONE;
        end else begin
          reps_left_d = reps_left_q - REP_ONE;
          if (gap_q == '0) begin
            idx_d = 2'd2;
          end else begin
            gap_cnt_d = gap_q;
            state_d   = GAP;
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_ONE) begin
          idx_d   = 2'd2;
          state_d = SEND;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_ONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered, so they are decoded from the state being entered;
  // the register then presents them for exactly that state's cycle.
  always_comb begin
    xout_d      = bus.idle_lvl;
    bit_valid_d = 1'b0;
    last_d      = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    case (state_d)
      SEND: begin
        xout_d      = seq_d[idx_d];
        bit_valid_d = 1'b1;
        last_d      = (idx_d == 2'd0);
        busy_d      = 1'b1;
      end
      GAP: begin
        xout_d = lvl_d;
        busy_d = 1'b1;
      end
      DONE: begin
        xout_d = lvl_d;
        done_d = 1'b1;
      end
      default: begin
        xout_d = bus.idle_lvl;
      end
    endcase
  end

  assign bus.xout      = xout_q;
  assign bus.bit_valid = bit_valid_q;
  assign bus.last      = last_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule
